// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register family:
// reset/flush payload constants, the occupancy state enum and
// the side-band field layout.
package pipe_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Occupancy of the stage: EMPTY, output register only, or output + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Side-band layout: low bits carry an exception code, top bit the delay-slot flag.
  localparam int SIDE_EXC_LSB = 0;
  localparam int SIDE_EXC_W   = 7;
  localparam int SIDE_DS_BIT  = 7;

  // True when the stage can take another beat in the given state.
  function automatic logic has_room(input pipe_state_t s);
    return (s != TWO);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: output register plus one skid register with the
// EMPTY/ONE/TWO occupancy machine. in_ready and out_valid are registered
// decodes of the next state, so no input reaches an output combinationally.
// The synchronous clear input empties the buffer and restores the reset
// payload; the enclosing stage gives it priority over the handshake.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int            PW          = 72,
  parameter logic [PW-1:0] RST_PAYLOAD = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  pipe_state_t   state;
  pipe_state_t   state_nx;
  logic [PW-1:0] skid_data;
  logic          accept;
  logic          consume;
  logic          load_out_in;
  logic          load_out_skid;
  logic          load_skid;

  // Next-state and register-load decode from the handshake events.
  always_comb begin
    accept        = in_valid && in_ready;
    consume       = out_valid && out_ready;
    state_nx      = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nx    = ONE;
          load_out_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          state_nx  = TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          state_nx      = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // State, registered handshake outputs and payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= RST_PAYLOAD;
      skid_data <= '0;
    end else if (clr) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= RST_PAYLOAD;
      skid_data <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= has_room(state_nx);
      out_valid <= (state_nx != EMPTY);
      if (load_out_in) begin
        out_data <= in_data;
      end else if (load_out_skid) begin
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake,
// two-entry skid buffer and synchronous flush. All outputs are registered.
// Optional feature macro: PIPE_STALL_CNT_EN adds the stall_cnt output, a
// saturating count of cycles with out_valid && !out_ready (cleared by reset
// only, not by flush).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 SIDE_W    = 8,
  parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(PC_RESET),
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(INSTR_NOP)
`ifdef PIPE_STALL_CNT_EN
  , parameter int               CNT_W     = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [SIDE_W-1:0]  out_side,
  input  logic               flush
`ifdef PIPE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int PW = PC_W + INSTR_W + SIDE_W;
  localparam logic [PW-1:0] RST_PAYLOAD = {RESET_PC, NOP_INSTR, {SIDE_W{1'b0}}};

  logic          in_valid_g;
  logic [PW-1:0] in_data;
  logic [PW-1:0] out_data;

  // Flush wins over every event: an offered beat is dropped in the flush
  // cycle and the buffer is cleared back to its reset contents.
  assign in_valid_g = in_valid && !flush;
  assign in_data    = {in_pc, in_instr, in_side};
  assign {out_pc, out_instr, out_side} = out_data;

  pipe_skid_buf #(
    .PW          (PW),
    .RST_PAYLOAD (RST_PAYLOAD)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clr       (flush),
    .in_valid  (in_valid_g),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`ifdef PIPE_STALL_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating stall counter; flush deliberately leaves it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
